alu_ctx_master: RTL and testbench

Byte-serial initiator for the ALU CSR "ctx" control interface. It accepts one 32-bit CSR read or write request on a parallel valid/ready port. For a write, it serializes the request into a command byte plus four data bytes on `ctx_val`/`ctx_out`. For a read, it collects the four response bytes from `ctx_in` at a fixed latency. It sits between the host/testbench agent and the ALU CSR responder, one transaction at a time.

---
 rtl/alu_ctx_pkg.sv | 39 +++
 rtl/alu_ctx_bytesr.sv | 46 ++++
 rtl/alu_ctx_master.sv | 208 ++++++++++++++++++++
 tb/tb_alu_ctx_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctx_pkg.sv
// alu_ctx_pkg
// Shared definitions for the ALU CSR "ctx" byte-serial initiator.
//   - ctx_state_e    : initiator FSM states
//   - CTX_*          : command byte layout and data width constants
//   - CSR_*          : known CSR addresses of the ALU responder
//   - CSR_UNMAPPED   : pattern the responder returns for unmapped reads
//   - ctx_cmd_byte() : builds the command byte from type and address
package alu_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } ctx_state_e;

  localparam int CTX_WR_BIT     = 7;
  localparam int CTX_ADDR_W     = 7;
  localparam int CTX_DATA_BYTES = 4;
  localparam int CTX_RD_LAT_DEF = 4;

  localparam logic [CTX_ADDR_W-1:0] CSR_KC  = 7'h20;
  localparam logic [CTX_ADDR_W-1:0] CSR_SOR = 7'h24;

  localparam logic [31:0] CSR_UNMAPPED = 32'hDEAD_BEEF;

  // Command byte: type flag in the top bit, CSR address below it.
  function automatic logic [7:0] ctx_cmd_byte(input logic                  wr,
                                               input logic [CTX_ADDR_W-1:0] addr);
    logic [7:0] b;
    b                 = '0;
    b[CTX_ADDR_W-1:0] = addr;
    b[CTX_WR_BIT]     = wr;
    return b;
  endfunction

endpackage

// File: rtl/alu_ctx_bytesr.sv
// alu_ctx_bytesr
// 32-bit byte-wide shift register. Moves towards the MSB one byte per
// shift, so the MSB byte leaves first and new bytes enter at the LSB.
// Load has priority over shift.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears contents)
//   load        : replace contents with load_data
//   load_data   : parallel load value
//   shift_en    : shift left by one byte, filling the LSB byte with shift_in
//   shift_in    : byte entering at the LSB end
//   data        : current contents
//   msb_byte    : current MSB byte (the next byte to leave)
module alu_ctx_bytesr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        shift_en,
  input  logic [7:0]  shift_in,
  output logic [31:0] data,
  output logic [7:0]  msb_byte
);

  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[23:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data     = data_q;
  assign msb_byte = data_q[31:24];

endmodule

// File: rtl/alu_ctx_master.sv
// alu_ctx_master
// Byte-serial initiator for the ALU CSR "ctx" interface. Takes one 32-bit
// CSR request at a time on a valid/ready port, sends a command byte (and
// for writes four data bytes, MSB first) on ctx_val/ctx_out, and for reads
// gathers four response bytes from ctx_in a fixed RD_LAT cycles after the
// command byte. Every transaction ends with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_write/addr/wdata   : request type, CSR address, write data
//   rsp_valid/write/rdata  : completion pulse, its type, read data (held)
//   ctx_val/ctx_out        : command strobe and command/data byte
//   ctx_in                 : read byte from the responder, sampled directly
// Parameter:
//   RD_LAT : cycles from command byte to first read byte, 2..7
module alu_ctx_master
  import alu_ctx_pkg::*;
#(
  parameter int RD_LAT = CTX_RD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [CTX_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic                  ctx_val,
  output logic [7:0]            ctx_out,
  input  logic [7:0]            ctx_in
);

  // RWAIT lasts RD_LAT-1 cycles, so its counter runs 0 .. RD_LAT-2.
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 2);
  localparam logic [1:0] BYTE_LAST = 2'(CTX_DATA_BYTES - 1);

  ctx_state_e            state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [2:0]            wait_cnt_q, wait_cnt_d;
  logic                  write_q, write_d;
  logic [CTX_ADDR_W-1:0] addr_q, addr_d;
  logic                  ctx_val_q, ctx_val_d;
  logic [7:0]            ctx_out_q, ctx_out_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic                  wr_load, wr_shift;
  logic                  rd_load, rd_shift;
  logic [31:0]           wr_data, rd_data;
  logic [7:0]            wr_msb, rd_msb;
  logic                  unused_bits;

  // Write data shifts out MSB first; zeros fill from the bottom.
  alu_ctx_bytesr u_wr_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wr_load),
    .load_data (req_wdata),
    .shift_en  (wr_shift),
    .shift_in  (8'h00),
    .data      (wr_data),
    .msb_byte  (wr_msb)
  );

  // Read bytes arrive MSB first and enter at the bottom.
  alu_ctx_bytesr u_rd_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_load),
    .load_data (32'h0000_0000),
    .shift_en  (rd_shift),
    .shift_in  (ctx_in),
    .data      (rd_data),
    .msb_byte  (rd_msb)
  );

  assign unused_bits = ^{wr_data, rd_msb, rd_data[31:24]};

  assign req_ready = (state_q == ST_IDLE);

  // Next-state, counters and request capture. The read response word is
  // formed from the final incoming byte so it is registered together with
  // the rsp_valid pulse rather than a cycle later.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_load     = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = ST_CMD;
          write_d    = req_write;
          addr_d     = req_addr;
          wr_load    = 1'b1;
          rd_load    = 1'b1;
          byte_cnt_d = '0;
          wait_cnt_d = '0;
        end
      end
      ST_CMD: begin
        state_d = write_q ? ST_WDATA : ST_RWAIT;
      end
      ST_WDATA: begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == BYTE_LAST) begin
          state_d = ST_RSP;
        end
      end
      ST_RWAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_RDATA;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      ST_RDATA: begin
        rd_shift   = 1'b1;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == BYTE_LAST) begin
          state_d     = ST_RSP;
          rsp_rdata_d = {rd_data[23:0], ctx_in};
        end
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up
  // with the cycle that state is occupied. Entering or staying in WDATA
  // presents the current MSB write byte and advances the shift register.
  always_comb begin
    ctx_val_d   = 1'b0;
    ctx_out_d   = 8'h00;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    wr_shift    = 1'b0;

    case (state_d)
      ST_CMD: begin
        ctx_val_d = 1'b1;
        ctx_out_d = ctx_cmd_byte(write_d, addr_d);
      end
      ST_WDATA: begin
        ctx_out_d = wr_msb;
        wr_shift  = 1'b1;
      end
      ST_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
      end
      default: begin
        ctx_out_d = 8'h00;
      end
    endcase
  end

  // All state, counters and registered outputs clear on reset, which also
  // drops any transaction in flight without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      ctx_val_q   <= 1'b0;
      ctx_out_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      ctx_val_q   <= ctx_val_d;
      ctx_out_q   <= ctx_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ctx_val   = ctx_val_q;
  assign ctx_out   = ctx_out_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_alu_ctx_master.sv
// tb_alu_ctx_master
// Directed bench for alu_ctx_master with a small behavioural ALU CSR
// responder: CSR 0x20 holds k_val/c_val (bytes [15:8]/[7:0]), CSR 0x24 is
// a clear-on-read accumulator of ALU results, other addresses read back
// 0xDEADBEEF. Read bytes are driven RD_LAT cycles after the command byte.
module tb_alu_ctx_master;

  localparam int RD_LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        ctx_val;
  logic [7:0]  ctx_out;
  logic [7:0]  ctx_in;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int accCyc = 0;

  alu_ctx_master #(.RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .ctx_val   (ctx_val),
    .ctx_out   (ctx_out),
    .ctx_in    (ctx_in)
  );

  // 10 ns clock plus a free-running cycle index used for timing checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural responder state.
  logic [7:0]  kVal, cVal;
  logic [31:0] sorAcc;
  logic        rdAct, wrAct;
  int          rdBase, wrBase;
  logic [6:0]  wrAddr;
  logic [31:0] wrSr, rdWord;
  logic        aluPush = 1'b0;
  logic [31:0] aluVal = '0;
  int          rdOff;

  // Responder: captures command bytes, collects write bytes, prepares the
  // read word (clearing the accumulator when it is read).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kVal   <= 8'h00;
      cVal   <= 8'h00;
      sorAcc <= '0;
      rdAct  <= 1'b0;
      wrAct  <= 1'b0;
      rdBase <= 0;
      wrBase <= 0;
      wrAddr <= '0;
      wrSr   <= '0;
      rdWord <= '0;
    end else begin
      if (aluPush) sorAcc <= sorAcc + aluVal;
      if (wrAct) begin
        wrSr <= {wrSr[23:0], ctx_out};
        if (cyc - wrBase == 4) begin
          wrAct <= 1'b0;
          if (wrAddr == 7'h20) begin
            kVal <= wrSr[7:0];
            cVal <= ctx_out;
          end
        end
      end
      if (rdAct && (cyc - rdBase == RD_LAT + 3)) rdAct <= 1'b0;
      if (ctx_val) begin
        if (ctx_out[7]) begin
          wrAct  <= 1'b1;
          wrBase <= cyc;
          wrAddr <= ctx_out[6:0];
          wrSr   <= '0;
        end else begin
          rdAct  <= 1'b1;
          rdBase <= cyc;
          case (ctx_out[6:0])
            7'h20:   rdWord <= {16'h0000, kVal, cVal};
            7'h24: begin
              rdWord <= sorAcc;
              sorAcc <= '0;
            end
            default: rdWord <= 32'hDEAD_BEEF;
          endcase
        end
      end
    end
  end

  // Read bytes, MSB first, in cycles RD_LAT .. RD_LAT+3 after the command.
  always @* begin
    rdOff  = cyc - rdBase;
    ctx_in = 8'h00;
    if (rdAct) begin
      case (rdOff - RD_LAT)
        0:       ctx_in = rdWord[31:24];
        1:       ctx_in = rdWord[23:16];
        2:       ctx_in = rdWord[15:8];
        3:       ctx_in = rdWord[7:0];
        default: ctx_in = 8'h00;
      endcase
    end
  end

  // Logs command and response timing during the back-to-back sequence.
  logic        monEn = 1'b0;
  int          cmdLog[8];
  int          cmdN = 0;
  logic [31:0] rspDataLog[8];
  logic        rspWrLog[8];
  int          rspN = 0;

  always @(negedge clk) begin
    if (monEn) begin
      if (ctx_val && cmdN < 8) begin
        cmdLog[cmdN] = cyc;
        cmdN++;
      end
      if (rsp_valid && rspN < 8) begin
        rspDataLog[rspN] = rsp_rdata;
        rspWrLog[rspN]   = rsp_write;
        rspN++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request (called at a negedge) and waits, bounded, for it to
  // be accepted. Returns at the negedge of the CMD cycle with accCyc = A.
  task automatic applyStimulus(input logic wr, input logic [6:0] addr,
                               input logic [31:0] wdata, input logic hold);
    int n;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {31'b0, req_ready}, 32'd1);
    accCyc = cyc;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic runWrite(input logic [6:0] addr, input logic [31:0] wdata,
                          input logic [7:0] expCmd);
    logic [7:0] expBytes [4];
    expBytes[0] = wdata[31:24];
    expBytes[1] = wdata[23:16];
    expBytes[2] = wdata[15:8];
    expBytes[3] = wdata[7:0];
    applyStimulus(1'b1, addr, wdata, 1'b0);
    checkOutput("wr_cmd_val", {31'b0, ctx_val}, 32'd1);
    checkOutput("wr_cmd_byte", {24'b0, ctx_out}, {24'b0, expCmd});
    checkOutput("wr_cmd_busy", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wr_data_val", {31'b0, ctx_val}, 32'd0);
      checkOutput("wr_data_byte", {24'b0, ctx_out}, {24'b0, expBytes[i]});
    end
    @(negedge clk);
    checkOutput("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("wr_rsp_write", {31'b0, rsp_write}, 32'd1);
    checkOutput("wr_rsp_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("wr_idle_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("wr_idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic runRead(input string tag, input logic [6:0] addr,
                         input logic [7:0] expCmd, input logic [31:0] expData);
    int early;
    applyStimulus(1'b0, addr, 32'hFFFF_FFFF, 1'b0);
    checkOutput({tag, "_cmd_val"}, {31'b0, ctx_val}, 32'd1);
    checkOutput({tag, "_cmd_byte"}, {24'b0, ctx_out}, {24'b0, expCmd});
    early = 0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      @(negedge clk);
      if (rsp_valid) early++;
    end
    checkOutput({tag, "_early_rsp"}, early, 0);
    @(negedge clk);
    checkOutput({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    checkOutput({tag, "_rsp_write"}, {31'b0, rsp_write}, 32'd0);
    checkOutput({tag, "_rdata"}, rsp_rdata, expData);
    @(negedge clk);
    checkOutput({tag, "_hold"}, rsp_rdata, expData);
    checkOutput({tag, "_idle_ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int a0, a1, a2, seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_ctx_val", {31'b0, ctx_val}, 32'd0);
    checkOutput("rst_ctx_out", {24'b0, ctx_out}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_write", {31'b0, rsp_write}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write 0x20 <= 0x00005A3C");
    runWrite(7'h20, 32'h0000_5A3C, 8'hA0);
    checkOutput("resp_k_val", {24'b0, kVal}, 32'h5A);
    checkOutput("resp_c_val", {24'b0, cVal}, 32'h3C);

    $display("[TB] read back 0x20 and unmapped 0x11");
    runRead("rd_kc", 7'h20, 8'h20, 32'h0000_5A3C);
    runRead("rd_unmapped", 7'h11, 8'h11, 32'hDEAD_BEEF);

    $display("[TB] accumulate 3 and 5, read 0x24 twice");
    aluVal  = 32'd3;
    aluPush = 1'b1;
    @(negedge clk);
    aluVal  = 32'd5;
    @(negedge clk);
    aluPush = 1'b0;
    runRead("rd_sor1", 7'h24, 8'h24, 32'h0000_0008);
    runRead("rd_sor2", 7'h24, 8'h24, 32'h0000_0000);

    $display("[TB] back-to-back write, read, write");
    monEn = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 7'h20, 32'h1234_ABCD, 1'b1);
    a0 = accCyc;
    applyStimulus(1'b0, 7'h20, 32'h0, 1'b1);
    a1 = accCyc;
    applyStimulus(1'b1, 7'h20, 32'h0000_0102, 1'b0);
    a2 = accCyc;
    repeat (10) @(negedge clk);
    monEn = 1'b0;
    checkOutput("b2b_accept_1", a1 - a0, 7);
    checkOutput("b2b_accept_2", a2 - a0, 17);
    checkOutput("b2b_cmd_count", cmdN, 3);
    checkOutput("b2b_cmd0_cyc", cmdLog[0], a0 + 1);
    checkOutput("b2b_cmd1_cyc", cmdLog[1], a1 + 1);
    checkOutput("b2b_cmd2_cyc", cmdLog[2], a2 + 1);
    checkOutput("b2b_rsp_count", rspN, 3);
    checkOutput("b2b_rsp0_write", {31'b0, rspWrLog[0]}, 32'd1);
    checkOutput("b2b_rsp1_write", {31'b0, rspWrLog[1]}, 32'd0);
    checkOutput("b2b_rsp1_rdata", rspDataLog[1], 32'h0000_ABCD);
    checkOutput("b2b_rsp2_write", {31'b0, rspWrLog[2]}, 32'd1);
    checkOutput("b2b_k_val", {24'b0, kVal}, 32'h01);
    checkOutput("b2b_c_val", {24'b0, cVal}, 32'h02);

    $display("[TB] reset during read data");
    applyStimulus(1'b0, 7'h20, 32'h0, 1'b0);
    repeat (RD_LAT + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("mid_rst_ctx_val", {31'b0, ctx_val}, 32'd0);
    checkOutput("mid_rst_ctx_out", {24'b0, ctx_out}, 32'd0);
    checkOutput("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("mid_rst_rsp_write", {31'b0, rsp_write}, 32'd0);
    checkOutput("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < RD_LAT + 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("mid_rst_no_rsp", seen, 0);
    runRead("rd_after_rst", 7'h20, 8'h20, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
